// File: rtl/demux_1_4_registrado_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
package demux_1_4_registrado_pkg;

    localparam int LARGURA_PADRAO = 32;
    localparam int NUM_SAIDAS     = 4;
    localparam int CONT_LARGURA   = 16;

    localparam logic [1:0] DEST_A = 2'b00;
    localparam logic [1:0] DEST_B = 2'b01;
    localparam logic [1:0] DEST_C = 2'b10;
    localparam logic [1:0] DEST_D = 2'b11;

endpackage

// File: rtl/demux_1_4_registrado_slot_saida.sv
// One output holding slot: a data register plus its valid bit.
// A load has priority over a drain, so a slot that is drained and reloaded
// in the same cycle stays valid with the new word.
module slot_saida #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic               drena,
    input  logic [LARGURA-1:0] dado,
    output logic [LARGURA-1:0] dado_saida,
    output logic               valido
);

    logic [LARGURA-1:0] r_dado;
    logic               r_valido;

    // Data register: captures the word on load, otherwise holds its value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dado <= '0;
        end else if (carrega) begin
            r_dado <= dado;
        end
    end

    // Valid bit: set on load, cleared on a drain with no reload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valido <= 1'b0;
        end else if (carrega) begin
            r_valido <= 1'b1;
        end else if (drena) begin
            r_valido <= 1'b0;
        end
    end

    assign dado_saida = r_dado;
    assign valido     = r_valido;

endmodule

// File: rtl/demux_1_4_registrado.sv
// Registered 1-to-4 demultiplexer with valid/ready on the input and on each
// output. Handshake: a transfer happens on a rising edge where valid and
// ready are both high; valid never depends on ready, and prontoEntrada
// depends only on controle and the addressed slot's state/consumer ready.
module demux_1_4_registrado
    import demux_1_4_registrado_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LARGURA-1:0]      entrada,
    input  logic [1:0]              controle,
    input  logic                    validoEntrada,
    output logic                    prontoEntrada,
    output logic [LARGURA-1:0]      saidaA,
    output logic [LARGURA-1:0]      saidaB,
    output logic [LARGURA-1:0]      saidaC,
    output logic [LARGURA-1:0]      saidaD,
    output logic [NUM_SAIDAS-1:0]   validoSaida,
    input  logic [NUM_SAIDAS-1:0]   prontoSaida,
    output logic [CONT_LARGURA-1:0] contagem
);

    logic [NUM_SAIDAS-1:0]   w_sel;
    logic [NUM_SAIDAS-1:0]   w_carrega;
    logic [NUM_SAIDAS-1:0]   w_drena;
    logic [NUM_SAIDAS-1:0]   w_valido;
    logic [LARGURA-1:0]      w_dados [NUM_SAIDAS];
    logic                    w_pronto;
    logic                    w_transf_entrada;
    logic [CONT_LARGURA-1:0] r_contagem;

    // One-hot decode of the destination code.
    always_comb begin
        w_sel = '0;
        case (controle)
            DEST_A:  w_sel = 4'b0001;
            DEST_B:  w_sel = 4'b0010;
            DEST_C:  w_sel = 4'b0100;
            DEST_D:  w_sel = 4'b1000;
            default: w_sel = '0;
        endcase
    end

    // Input is ready when the addressed slot is empty or draining this cycle.
    assign w_pronto         = !w_valido[controle] || prontoSaida[controle];
    assign w_transf_entrada = validoEntrada && w_pronto;
    assign w_carrega        = w_transf_entrada ? w_sel : '0;
    assign w_drena          = w_valido & prontoSaida;

    genvar g;
    generate
        for (g = 0; g < NUM_SAIDAS; g++) begin : g_slot
            slot_saida #(
                .LARGURA (LARGURA)
            ) u_slot (
                .clock      (clock),
                .reset      (reset),
                .carrega    (w_carrega[g]),
                .drena      (w_drena[g]),
                .dado       (entrada),
                .dado_saida (w_dados[g]),
                .valido     (w_valido[g])
            );
        end
    endgenerate

    // Accepted-word counter, wraps modulo 2^CONT_LARGURA.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (w_transf_entrada) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign prontoEntrada = w_pronto;
    assign validoSaida   = w_valido;
    assign saidaA        = w_dados[0];
    assign saidaB        = w_dados[1];
    assign saidaC        = w_dados[2];
    assign saidaD        = w_dados[3];
    assign contagem      = r_contagem;

endmodule
